// File: rtl/parallel_to_serial_pkg.sv
// Shared definitions for the parallel_to_serial slice: default geometry,
// the word-index width helper and the index type.
package parallel_to_serial_pkg;

    // A single-word beat still needs a 1-bit index so the buffer mux stays legal.
    function automatic int idxWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_N     = 8;
    localparam int DEFAULT_WIDTH = 16;
    localparam int IDX_W         = idxWidth(DEFAULT_N);

    typedef logic [IDX_W-1:0] idx_t;

endpackage

// File: rtl/p2s_word_buffer.sv
// N x Width word store loaded as a whole beat, read one word at a time by index.
module p2s_word_buffer
    import parallel_to_serial_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N,
    parameter int IdxW  = idxWidth(N)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      i_load,
    input  logic [0:N-1][Width-1:0]   i_data,
    input  logic [IdxW-1:0]           i_idx,
    output logic [Width-1:0]          o_word
);

    logic [0:N-1][Width-1:0] r_words;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_words <= '0;
        end else if (i_load) begin
            r_words <= i_data;
        end
    end

    assign o_word = r_words[i_idx];

endmodule

// File: rtl/parallel_to_serial.sv
// Splits one N-word parallel beat into N serial words, word 0 first.
// Optional macro PARALLEL_TO_SERIAL_LAST_EN adds a registered m_last_o output.
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int Width = DEFAULT_WIDTH,
    parameter int N     = DEFAULT_N
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      s_valid_i,
    output logic                      s_ready_o,
    input  logic [0:N-1][Width-1:0]   s_data_i,
    output logic                      m_valid_o,
    input  logic                      m_ready_i,
    output logic [Width-1:0]          m_data_o
`ifdef PARALLEL_TO_SERIAL_LAST_EN
    ,
    output logic                      m_last_o
`endif
);

    localparam int IdxW = idxWidth(N);

    logic            r_busy;
    logic [IdxW-1:0] r_idx;
    logic            w_atLast;
    logic            w_sReady;
    logic            w_sFire;
    logic            w_mFire;

    // A new beat may overwrite the buffer only as its final word leaves.
    assign w_atLast = (r_idx == IdxW'(N - 1));
    assign w_sReady = !r_busy | (w_atLast & m_ready_i);
    assign w_sFire  = s_valid_i & w_sReady;
    assign w_mFire  = r_busy & m_ready_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_busy <= 1'b0;
            r_idx  <= '0;
        end else if (w_sFire) begin
            r_busy <= 1'b1;
            r_idx  <= '0;
        end else if (w_mFire) begin
            if (w_atLast) begin
                r_busy <= 1'b0;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef PARALLEL_TO_SERIAL_LAST_EN
    logic r_last;

    // Tracks busy & (idx == N-1) one step ahead so the flag comes from a flop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last <= 1'b0;
        end else if (w_sFire) begin
            r_last <= (N == 1);
        end else if (w_mFire) begin
            r_last <= w_atLast ? 1'b0 : (r_idx == IdxW'(N - 2));
        end
    end

    assign m_last_o = r_last;
`endif

    p2s_word_buffer #(
        .Width (Width),
        .N     (N),
        .IdxW  (IdxW)
    ) u_buffer (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .i_load (w_sFire),
        .i_data (s_data_i),
        .i_idx  (r_idx),
        .o_word (m_data_o)
    );

    assign s_ready_o = w_sReady;
    assign m_valid_o = r_busy;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Self-checking bench for parallel_to_serial: a vector table, directed
// sequences and randomized traffic against a queue-based reference model.
module tb_parallel_to_serial;

    localparam int Width = 16;
    localparam int N     = 8;

    typedef logic [0:N-1][Width-1:0] beat_t;

    typedef struct {
        logic             rst;
        logic             sValid;
        logic             mReady;
        int               base;
        logic             expValid;
        logic             expReady;
        logic [Width-1:0] expData;
        logic             expLast;
    } vec_t;

    logic             clk_i     = 1'b0;
    logic             rst_i     = 1'b1;
    logic             s_valid_i = 1'b0;
    logic             m_ready_i = 1'b0;
    beat_t            s_data_i  = '0;
    logic             s_ready_o;
    logic             m_valid_o;
    logic [Width-1:0] m_data_o;
    logic             lastObs;

    int compared   = 0;
    int mismatched = 0;

    logic [Width-1:0] modelQ[$];
    logic [Width-1:0] modelShown = '0;

    vec_t vecs[11];

    parallel_to_serial #(.Width(Width), .N(N)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .s_valid_i (s_valid_i),
        .s_ready_o (s_ready_o),
        .s_data_i  (s_data_i),
        .m_valid_o (m_valid_o),
        .m_ready_i (m_ready_i),
        .m_data_o  (m_data_o)
`ifdef PARALLEL_TO_SERIAL_LAST_EN
        ,
        .m_last_o  (lastObs)
`endif
    );

`ifndef PARALLEL_TO_SERIAL_LAST_EN
    assign lastObs = 1'b0;
`endif

    always #5 clk_i = ~clk_i;

    function automatic beat_t mkBeat(input int base);
        beat_t b;
        for (int k = 0; k < N; k++) b[k] = Width'(base + k);
        return b;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic sv, input logic mr, input beat_t d);
        rst_i     = rst;
        s_valid_i = sv;
        m_ready_i = mr;
        s_data_i  = d;
    endtask

    // One clock against the reference model: the model is just the queue of
    // words still owed downstream plus the last word that was shown.
    task automatic modelCycle(input string tag, input logic rst, input logic sv,
                              input logic mr, input beat_t d, output logic accepted);
        logic             expReady;
        logic [Width-1:0] expData;
        logic             mFire;
        applyStimulus(rst, sv, mr, d);
        #2;
        expReady = (modelQ.size() == 0) || (modelQ.size() == 1 && mr);
        expData  = (modelQ.size() != 0) ? modelQ[0] : modelShown;
        checkOutput({tag, " m_valid"}, 32'(m_valid_o), 32'(modelQ.size() != 0));
        checkOutput({tag, " s_ready"}, 32'(s_ready_o), 32'(expReady));
        checkOutput({tag, " m_data"},  32'(m_data_o),  32'(expData));
`ifdef PARALLEL_TO_SERIAL_LAST_EN
        checkOutput({tag, " m_last"},  32'(lastObs),   32'(modelQ.size() == 1));
`endif
        accepted = !rst && sv && expReady;
        mFire    = (modelQ.size() != 0) && mr;
        @(posedge clk_i);
        #1;
        if (rst) begin
            modelQ.delete();
            modelShown = '0;
        end else begin
            if (mFire) modelShown = modelQ.pop_front();
            if (accepted) for (int k = 0; k < N; k++) modelQ.push_back(d[k]);
        end
    endtask

    initial begin
        logic  acc;
        logic  sv;
        beat_t held;
        int    base;

        // Idle-gap scenario written out as explicit expectations.
        vecs[0] = '{1'b1, 1'b1, 1'b1, 'h10, 1'b0, 1'b1, 16'h0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 'h10, 1'b0, 1'b1, 16'h0, 1'b0};
        for (int k = 0; k < N; k++)
            vecs[2 + k] = '{1'b0, 1'b0, 1'b1, 'h99, 1'b1, (k == N - 1),
                            Width'('h10 + k), (k == N - 1)};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 'h99, 1'b0, 1'b1, 16'h17, 1'b0};

        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        repeat (2) @(posedge clk_i);
        #1;

        for (int i = 0; i < 11; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].sValid, vecs[i].mReady, mkBeat(vecs[i].base));
            #2;
            checkOutput($sformatf("vec%0d m_valid", i), 32'(m_valid_o), 32'(vecs[i].expValid));
            checkOutput($sformatf("vec%0d s_ready", i), 32'(s_ready_o), 32'(vecs[i].expReady));
            checkOutput($sformatf("vec%0d m_data", i),  32'(m_data_o),  32'(vecs[i].expData));
`ifdef PARALLEL_TO_SERIAL_LAST_EN
            checkOutput($sformatf("vec%0d m_last", i),  32'(lastObs),   32'(vecs[i].expLast));
`endif
            @(posedge clk_i);
            #1;
        end

        // Reset with s_valid high: nothing may be accepted.
        modelQ.delete();
        modelShown = m_data_o;
        for (int i = 0; i < 3; i++) modelCycle($sformatf("rst%0d", i), 1'b1, 1'b1, 1'b1, mkBeat('h40), acc);

        // Basic streaming: new beat {k..k+7} after each accept, ready held high.
        base = 0;
        for (int i = 0; i < 3 * N + 2; i++) begin
            modelCycle($sformatf("basic%0d", i), 1'b0, 1'b1, 1'b1, mkBeat(base), acc);
            if (acc) base++;
        end

        // Backpressure: m_ready toggles every cycle.
        for (int i = 0; i < 4 * N; i++) begin
            modelCycle($sformatf("bp%0d", i), 1'b0, 1'b1, 1'(i % 2), mkBeat(base), acc);
            if (acc) base++;
        end
        for (int i = 0; i < 2 * N + 2; i++) modelCycle($sformatf("drain%0d", i), 1'b0, 1'b0, 1'(i % 2), '0, acc);

        // Reset while idx == 3, then a fresh beat starts at word 0.
        modelCycle("mid load", 1'b0, 1'b1, 1'b1, mkBeat('h100), acc);
        for (int i = 0; i < 3; i++) modelCycle($sformatf("mid%0d", i), 1'b0, 1'b0, 1'b1, '0, acc);
        modelCycle("mid rst", 1'b1, 1'b1, 1'b1, mkBeat('h300), acc);
        modelCycle("mid after", 1'b0, 1'b1, 1'b1, mkBeat('h200), acc);
        for (int i = 0; i < N + 1; i++) modelCycle($sformatf("post%0d", i), 1'b0, 1'b0, 1'b1, '0, acc);

        // Randomized traffic; the producer holds its beat until accepted.
        sv   = 1'b0;
        held = '0;
        for (int i = 0; i < 400; i++) begin
            if (!sv) begin
                sv = 1'($urandom_range(0, 1));
                for (int k = 0; k < N; k++) held[k] = Width'($urandom);
            end
            modelCycle($sformatf("rnd%0d", i), 1'(($urandom_range(0, 99)) < 2), sv,
                       1'($urandom_range(0, 3) != 0), held, acc);
            if (acc || rst_i) sv = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Converts one N-word parallel beat into N consecutive single-word beats, word 0 first. It sits between a block-level producer (e.g. a DCT row/column stage emitting a full vector per beat) and a word-serial consumer. Both sides use valid/ready handshakes, and throughput is one output word per cycle with back-to-back input acceptance.

## Interface
- `Width`, 16: bits per word (≥1).
- `N`, 8: words per parallel beat (≥1).
- `clk_i` input 1: single clock, rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `s_valid_i` input 1: parallel beat valid.
- `s_ready_o` output 1: block can accept a parallel beat.
- `s_data_i` input [0:N-1][Width-1:0]: parallel beat; element 0 is output first.
- `m_valid_o` output 1: serial word valid.
- `m_ready_i` input 1: downstream accepts the serial word.
- `m_data_o` output [Width-1:0]: serial word.
- `m_last_o` output 1: only present with `PARALLEL_TO_SERIAL_LAST_EN`.

## Operation
- State: buffer of N words, word index `idx` (0..N-1), `busy` flag.
- Input handshake: a beat is taken when `s_valid_i & s_ready_o`.
- `s_ready_o = !busy | (idx == N-1 & m_ready_i)`.
- The only combinational path is `m_ready_i` → `s_ready_o`.
- On input handshake:
  - capture all N words;
  - set `idx = 0` and `busy = 1`.
- `m_valid_o = busy`. `m_data_o = buffer[idx]`, driven from registers only; there is no path from `s_data_i` to `m_data_o`.
- On output handshake (`m_valid_o & m_ready_i`):
  - if `idx < N-1`: increment `idx`;
  - if `idx == N-1` and no simultaneous input handshake: clear `busy`;
  - if `idx == N-1` with a simultaneous input handshake: load the new beat and keep `busy = 1`.
- Backpressure: while `m_valid_o & !m_ready_i`, `m_data_o` and `idx` hold.
- A beat presented while busy and not at the last word is not accepted; the producer holds `s_valid_i`/`s_data_i`.
- N=1: the block behaves as a one-deep register slice.
- `s_data_i` is ignored when no input handshake occurs.

## Timing
- Reset values:
  - `busy=0`, `idx=0`, buffer=0;
  - `m_valid_o=0`, `m_data_o=0`, `m_last_o=0`;
  - `s_ready_o=1` from the first cycle after reset.
- Latency: word 0 appears on `m_valid_o`/`m_data_o` in the cycle after the input handshake.
- Throughput: with `s_valid_i` and `m_ready_i` held high, `m_valid_o` stays high continuously and an input handshake occurs every N cycles.
- Reset mid-operation: pending words are discarded. Outputs return to reset values on the next edge.

## Configuration
- `PARALLEL_TO_SERIAL_LAST_EN` defined:
  - adds output `m_last_o`, equal to `busy & (idx == N-1)`;
  - `m_last_o` is registered state, not a combinational function of any input.
- Not defined: no `m_last_o` port. All other behaviour is identical.

## Structure
- Package `parallel_to_serial_pkg` holds:
  - `IDX_W = (N>1) ? $clog2(N) : 1`, provided as a function of N;
  - the index typedef `idx_t`.
- Sub-module `p2s_word_buffer`: N×Width load-enabled register array with read mux by index.
- The handshake/index control stays in the top module.

## Test plan
All scenarios use N=8, Width=16.
- Basic: after reset, present `s_data_i={0..7}` with `s_valid_i=1` and `m_ready_i=1`; after each accept, the next beat is `{k..k+7}`. Required response:
  - `m_data_o` is 0,1,…,7 on consecutive cycles from the cycle after the first accept, then 1..8, then 2..9;
  - `m_valid_o` has no gaps.
- Backpressure: toggle `m_ready_i` every cycle. Each word is held until accepted, the sequence is unchanged, and `s_ready_o` rises only in cycles with `idx=7 & m_ready_i=1`.
- Idle gap: one beat, then `s_valid_i=0`. After word 7 is accepted, `m_valid_o=0` and `s_ready_o=1`.
- Reset mid-stream: assert `rst_i` while `idx=3`. Next cycle: `m_valid_o=0`, `m_data_o=0`, `s_ready_o=1`. The next beat starts from word 0.
- Reset values: `m_valid_o=0` throughout reset even with `s_valid_i=1`. No accept occurs while `rst_i=1`.
- LAST_EN build: `m_last_o=1` only with word 7 of each beat, including under backpressure.
